// File: rtl/seq_det_sched.sv
// Round-robin time-multiplexed serial pattern detector shared by NCH bit-serial requesters.
// Optional per-channel saturating match counters are built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_det_sched #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 2,
    parameter logic [PLEN-1:0] PATTERN = 2'b11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           din,
    input  logic [NCH-1:0]           clr,
    output logic [NCH-1:0]           ack,
    output logic                     match_vld,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic                     busy,
    input  logic [$clog2(NCH)-1:0]   cnt_sel,
    output logic [7:0]               cnt_rdata
);

    localparam int CW = $clog2(NCH);
    localparam int FW = $clog2(PLEN + 1);

    logic [PLEN-1:0] hist_q [NCH];
    logic [PLEN-1:0] hist_d [NCH];
    logic [FW-1:0]   fill_q [NCH];
    logic [FW-1:0]   fill_d [NCH];
    logic [CW-1:0]   rr_last_q, rr_last_d;
    logic            match_vld_q, match_vld_d;
    logic [CW-1:0]   match_ch_q, match_ch_d;
    logic            busy_q, busy_d;

    logic            grant_vld;
    logic [CW-1:0]   grant_idx;
    logic [CW-1:0]   cand;
    logic [PLEN-1:0] base_hist, new_hist;
    logic [PLEN:0]   shift_hist;
    logic [FW-1:0]   base_fill, new_fill;
    logic            hit;

    // Search starts just after the last winner; ack is forced low while reset is asserted.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(rr_last_q) + k) % NCH);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        ack = '0;
        if (grant_vld) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // A same-cycle clear discards the old context before the granted bit is shifted in.
    always_comb begin
        base_hist  = clr[grant_idx] ? '0 : hist_q[grant_idx];
        base_fill  = clr[grant_idx] ? '0 : fill_q[grant_idx];
        shift_hist = {base_hist, din[grant_idx]};
        new_hist   = shift_hist[PLEN-1:0];
        new_fill   = (int'(base_fill) >= PLEN) ? FW'(PLEN) : base_fill + 1'b1;
        hit        = grant_vld && (new_hist == PATTERN) && ((int'(base_fill) + 1) >= PLEN);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hist_d[i] = clr[i] ? '0 : hist_q[i];
            fill_d[i] = clr[i] ? '0 : fill_q[i];
            if (grant_vld && (grant_idx == CW'(i))) begin
                hist_d[i] = new_hist;
                fill_d[i] = new_fill;
            end
        end
        rr_last_d   = grant_vld ? grant_idx : rr_last_q;
        match_vld_d = hit;
        match_ch_d  = hit ? grant_idx : match_ch_q;
        busy_d      = |req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
            end
            rr_last_q   <= CW'(NCH - 1);
            match_vld_q <= 1'b0;
            match_ch_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= hist_d[i];
                fill_q[i] <= fill_d[i];
            end
            rr_last_q   <= rr_last_d;
            match_vld_q <= match_vld_d;
            match_ch_q  <= match_ch_d;
            busy_q      <= busy_d;
        end
    end

    assign match_vld = match_vld_q;
    assign match_ch  = match_ch_q;
    assign busy      = busy_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [7:0] cnt_q [NCH];
    logic [7:0] cnt_d [NCH];

    // Clear applies first so a clear-plus-hit cycle leaves the counter at 1.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = clr[i] ? 8'd0 : cnt_q[i];
            if (hit && (grant_idx == CW'(i)) && (cnt_d[i] != 8'hFF)) begin
                cnt_d[i] = cnt_d[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt_rdata = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : 8'd0;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_rdata      = 8'd0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: queue-based reference model of arbitration and per-channel history.
module tb_seq_det_sched;

    localparam int NCH  = 4;
    localparam int PLEN = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   req, din, clr, ack;
    logic             match_vld, busy;
    logic [1:0]       match_ch, cnt_sel;
    logic [7:0]       cnt_rdata;

    seq_det_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN(2'b11)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .clr(clr), .ack(ack),
        .match_vld(match_vld), .match_ch(match_ch), .busy(busy),
        .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; int ch; } exp_t;
    exp_t exp_q[$];

    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    bit   exp_busy = 0;

    // Reference model state
    int   m_rr;
    bit   m_hist[NCH][$];
    int   m_cnt[NCH];
    int   grants[NCH];
    logic [PLEN-1:0] pat = 2'b11;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = NCH - 1;
        for (int i = 0; i < NCH; i++) begin
            m_hist[i].delete();
            m_cnt[i] = 0;
        end
        exp_q.delete();
        exp_busy = 0;
    endtask

    // Drive one cycle of stimulus, check ack/cnt_rdata, advance the model.
    task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] d, input logic [NCH-1:0] c);
        int g;
        bit h;
        int sel;
        @(negedge clk);
        req = r; din = d; clr = c;
        sel = $urandom_range(0, NCH - 1);
        cnt_sel = sel[1:0];
        #1;
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (m_rr + k) % NCH;
            if (g < 0 && r[idx]) g = idx;
        end
        check("ack", int'(ack), (g >= 0) ? (1 << g) : 0);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("cnt_rdata", int'(cnt_rdata), m_cnt[sel]);
`else
        check("cnt_rdata", int'(cnt_rdata), 0);
`endif
        for (int i = 0; i < NCH; i++) begin
            if (c[i]) begin
                m_hist[i].delete();
                m_cnt[i] = 0;
            end
        end
        if (g >= 0) begin
            m_hist[g].push_back(d[g]);
            if (m_hist[g].size() > PLEN) void'(m_hist[g].pop_front());
            h = (m_hist[g].size() == PLEN);
            for (int k = 0; k < PLEN; k++) begin
                if (h && m_hist[g][PLEN - 1 - k] != pat[k]) h = 0;
            end
            if (h) begin
                if (m_cnt[g] < 255) m_cnt[g]++;
                exp_q.push_back('{tag: edge_cnt + 1, ch: g});
            end
            grants[g]++;
            m_rr = g;
        end
        exp_busy = |r;
    endtask

    // Monitor: compare registered outputs against the scoreboard after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("busy", int'(busy), int'(exp_busy));
            if (match_vld) begin
                if (exp_q.size() > 0 && exp_q[0].tag == edge_cnt) begin
                    check("match_ch", int'(match_ch), exp_q[0].ch);
                    void'(exp_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL match_vld: got 1 expected 0 (ch=%0d t=%0t)", match_ch, $time);
                end
            end else if (exp_q.size() > 0 && exp_q[0].tag == edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL match_vld: got 0 expected 1 (ch=%0d t=%0t)", exp_q[0].ch, $time);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; din = '0; clr = '0; cnt_sel = 2'd0;
        model_reset();
        #23;
        check("rst_ack", int'(ack), 0);
        check("rst_match_vld", int'(match_vld), 0);
        check("rst_match_ch", int'(match_ch), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt_rdata", int'(cnt_rdata), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single channel stream 0,1,1,1,0 -> hits after 3rd and 4th bits
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000);

        // Fairness
        for (int i = 0; i < NCH; i++) grants[i] = 0;
        for (int n = 0; n < 8; n++) step(4'b1111, 4'($urandom), 4'b0000);
        for (int i = 0; i < NCH; i++) check("fair_grants", grants[i], 2);

        // Context isolation
        step(4'b0000, 4'b0000, 4'b1111);
        for (int n = 0; n < 4; n++) step(4'b0110, 4'b1111, 4'b0000);

        // Clear collision on ch0
        step(4'b0000, 4'b0000, 4'b0001);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0001);
        step(4'b0001, 4'b0001, 4'b0000);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            logic [NCH-1:0] c;
            c = (($urandom_range(0, 15)) == 0) ? 4'($urandom) : 4'b0000;
            step(4'($urandom), 4'($urandom), c);
        end

        // Asynchronous reset between edges with traffic in flight
        step(4'b1111, 4'b1111, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", int'(ack), 0);
        check("arst_match_vld", int'(match_vld), 0);
        check("arst_busy", int'(busy), 0);
        model_reset();
        req = '0; din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1000, 4'b1000, 4'b0000);
        step(4'b1000, 4'b1000, 4'b0000);
        step(4'b1000, 4'b1000, 4'b0000);

        // Counter saturation and clear on ch3
        for (int n = 0; n < 300; n++) step(4'b1000, 4'b1000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        cnt_sel = 2'd3;
        #1;
`ifdef SEQ_DET_MATCH_CNT_EN
        check("cnt_sat", int'(cnt_rdata), 255);
`else
        check("cnt_off", int'(cnt_rdata), 0);
`endif
        step(4'b0000, 4'b0000, 4'b1000);
        step(4'b0000, 4'b0000, 4'b0000);
        cnt_sel = 2'd3;
        #1;
        check("cnt_clr", int'(cnt_rdata), 0);

        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
